// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered flags, iterative shifts and a shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int AW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] rdest,
  input  logic [WIDTH-1:0] rsrc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags,
  output logic             illegal,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [4:0] opr, alu_f;
  logic [WIDTH-1:0] sh, sh_nx, mcand, alu_r;
  logic [2*WIDTH-1:0] prod, prod_nx;
  logic [WIDTH:0] sum, add_s, sub_d;
  logic [AW-1:0] k;
  logic accept, cin, sh_out, last;
  assign k = rsrc[AW-1:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == SHIFT || state == MUL;
  assign accept = in_valid && in_ready;
  assign cin = flags[0] && (op == 5'd10 || op == 5'd11);
  assign last = cnt == CW'(1);
  // sequencing: multi-cycle ops count down in SHIFT/MUL, everything else goes straight to DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (op == 5'd12) ? MUL : (op >= 5'd7 && op <= 5'd9 && k != '0) ? SHIFT : DONE;
      SHIFT:   if (last) state_nx = DONE;
      MUL:     if (last) state_nx = DONE;
      default: if (out_ready) state_nx = IDLE;
    endcase
  end
  // single-cycle result and flags, evaluated on the operands being accepted
  always_comb begin
    add_s = {1'b0, rdest} + {1'b0, rsrc} + {{WIDTH{1'b0}}, cin};
    sub_d = {1'b0, rdest} - {1'b0, rsrc} - {{WIDTH{1'b0}}, cin};
    alu_r = '0;
    alu_f = flags;
    case (op)
      5'd0, 5'd10: begin
        alu_r = add_s[WIDTH-1:0];
        alu_f[0] = add_s[WIDTH];
        alu_f[2] = (rdest[WIDTH-1] == rsrc[WIDTH-1]) && (add_s[WIDTH-1] != rdest[WIDTH-1]);
      end
      5'd1, 5'd11: begin
        alu_r = sub_d[WIDTH-1:0];
        alu_f[0] = sub_d[WIDTH];
        alu_f[2] = (rdest[WIDTH-1] != rsrc[WIDTH-1]) && (sub_d[WIDTH-1] != rdest[WIDTH-1]);
      end
      5'd2: begin
        alu_r = result;
        alu_f[1] = rdest < rsrc;
        alu_f[4] = $signed(rdest) < $signed(rsrc);
      end
      5'd3: alu_r = rdest & rsrc;
      5'd4: alu_r = rdest | rsrc;
      5'd5: alu_r = rdest ^ rsrc;
      5'd6: alu_r = ~rsrc;
      5'd7, 5'd8, 5'd9: begin
        alu_r = rdest;
        alu_f[0] = 1'b0;
      end
      default: ;
    endcase
    if (op <= 5'd11) alu_f[3] = (op == 5'd2) ? (rdest == rsrc) : ~|alu_r;
  end
  // one shift step and one shift-add multiply step per cycle
  always_comb begin
    sh_nx = (opr == 5'd7) ? {sh[WIDTH-2:0], 1'b0} : {(opr == 5'd9) & sh[WIDTH-1], sh[WIDTH-1:1]};
    sh_out = (opr == 5'd7) ? sh[WIDTH-1] : sh[0];
    sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nx = {sum, prod[WIDTH-1:1]};
  end
  // state, operand capture and result/flag writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      result <= '0;
      flags <= '0;
      illegal <= 1'b0;
      cnt <= '0;
      opr <= '0;
      sh <= '0;
      mcand <= '0;
      prod <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          opr <= op;
          sh <= rdest;
          mcand <= rdest;
          prod <= {{WIDTH{1'b0}}, rsrc};
          cnt <= (op == 5'd12) ? CW'(WIDTH) : CW'(k);
          illegal <= op > 5'd12;
          if (state_nx == DONE) begin
            result <= alu_r;
            flags <= alu_f;
          end
        end
        SHIFT: begin
          sh <= sh_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            result <= sh_nx;
            flags[0] <= sh_out;
            flags[3] <= ~|sh_nx;
          end
        end
        MUL: begin
          prod <= prod_nx;
          cnt <= cnt - CW'(1);
          if (last) begin
            result <= prod_nx[WIDTH-1:0];
            flags[2] <= |prod_nx[2*WIDTH-1:WIDTH];
            flags[3] <= ~|prod_nx[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random operations checked against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 16;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [4:0] op, flags;
  logic [W-1:0] rdest, rsrc, result;
  logic [W-1:0] m_res;
  logic [4:0] m_flags;
  int tests = 0;
  int fails = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .rdest(rdest), .rsrc(rsrc), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // expected result, flags ([0]C [1]L [2]F [3]Z [4]N), illegal and latency from plain arithmetic
  task automatic model(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [4:0] f, output logic il, output int lat);
    int ua, ub, sa, sb, s, ss, k, c;
    longint p;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    k = int'(b[3:0]);
    c = (o == 5'd10 || o == 5'd11) ? int'(m_flags[0]) : 0;
    r = m_res;
    f = m_flags;
    il = 1'b0;
    lat = 1;
    if (o == 5'd0 || o == 5'd10) begin
      s = ua + ub + c;
      ss = sa + sb + c;
      r = s[W-1:0];
      f[0] = s > 65535;
      f[2] = ss > 32767 || ss < -32768;
    end else if (o == 5'd1 || o == 5'd11) begin
      s = ua - ub - c;
      ss = sa - sb - c;
      r = s[W-1:0];
      f[0] = s < 0;
      f[2] = ss > 32767 || ss < -32768;
    end else if (o == 5'd2) begin
      f[1] = ua < ub;
      f[4] = sa < sb;
      f[3] = ua == ub;
    end else if (o == 5'd3) r = a & b;
    else if (o == 5'd4) r = a | b;
    else if (o == 5'd5) r = a ^ b;
    else if (o == 5'd6) r = ~b;
    else if (o >= 5'd7 && o <= 5'd9) begin
      if (k == 0) begin
        r = a;
        f[0] = 1'b0;
      end else begin
        lat = k + 1;
        if (o == 5'd7) begin
          s = ua << k;
          f[0] = s[W];
        end else begin
          s = (o == 5'd8) ? (ua >> k) : (sa >>> k);
          f[0] = ua[k-1];
        end
        r = s[W-1:0];
      end
    end else if (o == 5'd12) begin
      p = longint'(ua) * longint'(ub);
      r = p[W-1:0];
      f[2] = (p >> W) != 0;
      lat = W + 1;
    end else begin
      r = '0;
      il = 1'b1;
    end
    if (o <= 5'd12 && o != 5'd2) f[3] = r == '0;
  endtask

  // issue one op from IDLE, wait for out_valid, check, optionally stall, then drain
  task automatic run(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic [4:0] ef;
    logic ei;
    int elat, lat;
    model(o, a, b, er, ef, ei, elat);
    chk("in_ready_idle", 32'(in_ready), 32'(1));
    in_valid = 1'b1; op = o; rdest = a; rsrc = b; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    op = 5'($urandom); rdest = W'($urandom); rsrc = W'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat <= W + 20) begin
      chk("busy", 32'(busy), 32'(1));
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(elat));
    chk("result", 32'(result), 32'(er));
    chk("flags", 32'(flags), 32'(ef));
    chk("illegal", 32'(illegal), 32'(ei));
    chk("in_ready_done", 32'(in_ready), 32'(0));
    chk("busy_done", 32'(busy), 32'(0));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 5'd6;
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_result", 32'(result), 32'(er));
      chk("hold_flags", 32'(flags), 32'(ef));
      chk("hold_in_ready", 32'(in_ready), 32'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drained_valid", 32'(out_valid), 32'(0));
    chk("drained_ready", 32'(in_ready), 32'(1));
    m_res = er;
    m_flags = ef;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; rdest = '0; rsrc = '0;
    m_res = '0; m_flags = '0;
    repeat (2) @(negedge clk);
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_flags", 32'(flags), 32'(0));
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_illegal", 32'(illegal), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    run(5'd0, 16'h7FFF, 16'h0001, 3);
    run(5'd0, 16'hFFFF, 16'h0001, 0);
    run(5'd10, 16'h0000, 16'h0000, 0);
    run(5'd2, 16'h0001, 16'hFFFF, 0);
    run(5'd2, 16'h0005, 16'h0005, 0);
    run(5'd9, 16'h8001, 16'h0003, 0);
    run(5'd7, 16'h8000, 16'h0001, 0);
    run(5'd12, 16'h0100, 16'h0100, 0);
    run(5'd12, 16'h00FF, 16'h0003, 0);
    run(5'd1, 16'h0000, 16'h0001, 0);
    run(5'd11, 16'h0005, 16'h0004, 1);
    in_valid = 1'b1; op = 5'd12; rdest = 16'h1234; rsrc = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mul_busy", 32'(busy), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'(0));
    chk("abort_flags", 32'(flags), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_in_ready", 32'(in_ready), 32'(1));
    m_res = '0;
    m_flags = '0;
    run(5'd20, 16'hABCD, 16'h1234, 0);
    run(5'd1, 16'h8000, 16'h0001, 0);
    run(5'd31, 16'h0001, 16'h0001, 0);
    for (int i = 0; i < 80; i++)
      run(5'($urandom_range(0, 15)), W'($urandom), W'($urandom), int'($urandom_range(0, 1)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
